// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART byte width and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first request at or above
//               the pointer, wrapping, wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          any
);

    logic [N-1:0] w_cand;

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N) ? (s - N) : s;
    endfunction

    // Scan from farthest to nearest so the request closest to ptr overwrites.
    always_comb begin
        winner = '0;
        w_cand = '0;
        any    = |req;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = {{(N-1){1'b0}}, 1'b1} << wrap_idx(int'(ptr), i);
            if ((req & w_cand) != '0) begin
                winner = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-atomic round-robin arbiter sharing one UART transmitter
//               between N_PORTS byte-stream requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_PORTS       = 4,
    parameter int MAX_BURST     = 16,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [UART_BYTE_W*N_PORTS-1:0] i_req_data,
    input  logic [N_PORTS-1:0]             i_req_valid,
    input  logic [N_PORTS-1:0]             i_req_last,
    output logic [N_PORTS-1:0]             o_req_ready,
    output logic [UART_BYTE_W-1:0]         o_tx_data,
    output logic                           o_tx_data_valid,
    input  logic                           i_tx_data_rdy,
    output logic [N_PORTS-1:0]             o_grant,
    output logic                           o_busy
);

    localparam int         PTR_W        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [7:0] c_burst_last = 8'(MAX_BURST - 1);
    localparam logic [7:0] c_stall_last = 8'(STALL_TIMEOUT - 1);

    logic [0:0]             r_state, w_state_nxt;
    logic [N_PORTS-1:0]     r_grant, w_grant_nxt;
    logic [PTR_W-1:0]       r_ptr, w_ptr_nxt, w_ptr_after;
    logic [7:0]             r_burst, w_burst_nxt;
    logic [7:0]             r_stall, w_stall_nxt;
    logic [N_PORTS-1:0]     w_pick;
    logic                   w_any;
    logic                   w_valid_g, w_last_g, w_xfer, w_release;
    logic [UART_BYTE_W-1:0] w_data_g;

    rr_pick #(
        .N  (N_PORTS),
        .PW (PTR_W)
    ) u_pick (
        .req    (i_req_valid),
        .ptr    (r_ptr),
        .winner (w_pick),
        .any    (w_any)
    );

    // Owner's byte and the pointer value that follows the owner on release.
    always_comb begin
        w_data_g    = '0;
        w_ptr_after = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (r_grant[k]) begin
                w_data_g    = i_req_data[k*UART_BYTE_W +: UART_BYTE_W];
                w_ptr_after = (k == N_PORTS - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    assign w_valid_g = |(i_req_valid & r_grant);
    assign w_last_g  = |(i_req_last & r_grant);
    assign w_xfer    = w_valid_g & i_tx_data_rdy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_burst <= w_burst_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = r_burst;
        w_stall_nxt = r_stall;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_pick;
                    w_burst_nxt = '0;
                    w_stall_nxt = '0;
                end
            end
            S_GRANT: begin
                if (w_xfer) begin
                    if (w_last_g || (r_burst == c_burst_last)) begin
                        w_release = 1'b1;
                    end else begin
                        w_burst_nxt = r_burst + 8'd1;
                        w_stall_nxt = '0;
                    end
                end else if (!w_valid_g) begin
                    if (r_stall == c_stall_last) begin
                        w_release = 1'b1;
                    end else begin
                        w_stall_nxt = r_stall + 8'd1;
                    end
                end else begin
                    // Transmitter backpressure: owner is still presenting a byte.
                    w_stall_nxt = '0;
                end
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_after;
                    w_burst_nxt = '0;
                    w_stall_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        o_busy          = (r_state == S_GRANT);
        o_grant         = r_grant;
        o_req_ready     = r_grant & {N_PORTS{i_tx_data_rdy}};
        o_tx_data_valid = 1'b0;
        o_tx_data       = '0;
        if (r_state == S_GRANT) begin
            o_tx_data_valid = w_valid_g;
            o_tx_data       = w_data_g;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter with queued requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [8*NP-1:0] req_data;
    logic [NP-1:0]   req_valid, req_last, req_ready, grant;
    logic [7:0]      tx_data;
    logic            tx_valid, tx_rdy, busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_PORTS       (NP),
        .MAX_BURST     (4),
        .STALL_TIMEOUT (8)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_data      (req_data),
        .i_req_valid     (req_valid),
        .i_req_last      (req_last),
        .o_req_ready     (req_ready),
        .o_tx_data       (tx_data),
        .o_tx_data_valid (tx_valid),
        .i_tx_data_rdy   (tx_rdy),
        .o_grant         (grant),
        .o_busy          (busy)
    );

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
        logic       last;
    } item_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
    } exp_t;

    item_t pq[$];
    exp_t  exq[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic send(input int port, input logic [7:0] data, input logic last);
        item_t it;
        exp_t  e;
        it.port = 2'(port);
        it.data = data;
        it.last = last;
        pq.push_back(it);
        e.grant = 4'b0001 << port;
        e.data  = data;
        exq.push_back(e);
    endtask

    task automatic apply_inputs();
        bit found;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int k = 0; k < NP; k++) begin
            found = 1'b0;
            for (int i = 0; i < pq.size(); i++) begin
                if (!found && pq[i].port == 2'(k)) begin
                    found              = 1'b1;
                    req_valid[k]       = 1'b1;
                    req_last[k]        = pq[i].last;
                    req_data[8*k +: 8] = pq[i].data;
                end
            end
        end
    endtask

    // Requester models plus tx-side monitor: sample mid-cycle, retire after the edge.
    task automatic run_agents();
        logic [NP-1:0] hs;
        logic [NP-1:0] prev_grant;
        exp_t          e;
        bit            done;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            if (tx_valid && tx_rdy) begin
                if (exq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_tx: got grant %0h data %0h, expected no transfer", grant, tx_data);
                end else begin
                    e = exq.pop_front();
                    check("tx_byte", {20'd0, grant, tx_data}, {20'd0, e.grant, e.data});
                end
            end
            if (grant != '0 && grant != prev_grant) begin
                check("idle_bubble", {28'd0, prev_grant}, 32'd0);
            end
            prev_grant = grant;
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int k = 0; k < NP; k++) begin
                    done = 1'b0;
                    if (hs[k]) begin
                        for (int i = 0; i < pq.size(); i++) begin
                            if (!done && pq[i].port == 2'(k)) begin
                                pq.delete(i);
                                done = 1'b1;
                            end
                        end
                    end
                end
            end
            apply_inputs();
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (exq.size() == 0 && pq.size() == 0 && grant == '0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: drain timeout, got %0d bytes pending, expected 0", name, exq.size());
        end
    endtask

    task automatic wait_grant(input logic [NP-1:0] g, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (grant == g) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: grant wait timeout, got %0h, expected %0h", name, grant, g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        tx_rdy    = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        rst       = 1'b1;
        fork
            run_agents();
        join_none

        repeat (3) @(negedge clk);
        check("reset_state", {14'd0, grant, req_ready, tx_valid, tx_data, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 3-byte packet on port 2, one cycle of grant latency.
        send(2, 8'h41, 1'b0);
        send(2, 8'h42, 1'b0);
        send(2, 8'h43, 1'b1);
        @(negedge clk);
        check("t1_latency", {27'd0, grant, busy}, 32'd0);
        @(negedge clk);
        check("t1_grant", {27'd0, grant, busy}, {27'd0, 4'b0100, 1'b1});
        wait_drain(50, "t1_drain");
        check("t1_idle", {27'd0, grant, busy}, 32'd0);

        // Pointer sits at 3, so port 3 beats port 0.
        send(3, 8'h30, 1'b1);
        send(0, 8'h10, 1'b1);
        wait_drain(50, "ptr_drain");

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Contention from pointer 0: order 0, 1, 3.
        send(0, 8'h01, 1'b0);
        send(0, 8'h02, 1'b1);
        send(1, 8'h11, 1'b0);
        send(1, 8'h12, 1'b1);
        send(3, 8'h31, 1'b0);
        send(3, 8'h32, 1'b1);
        wait_drain(60, "cont_drain");

        // Burst limit 4: port 1 split around port 2's packet.
        for (int i = 0; i < 4; i++) send(1, 8'hA0 + 8'(i), 1'b0);
        send(2, 8'hB0, 1'b0);
        send(2, 8'hB1, 1'b1);
        for (int i = 4; i < 9; i++) send(1, 8'hA0 + 8'(i), 1'b0);
        send(1, 8'hA9, 1'b1);
        wait_drain(100, "burst_drain");

        // Stall timeout 8: release on the 8th low-valid cycle.
        send(0, 8'hC0, 1'b0);
        wait_grant(4'b0001, 20, "stall_grant");
        send(3, 8'hD0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stall_hold", {28'd0, grant}, 32'h1);
        end
        @(negedge clk);
        check("stall_release", {28'd0, grant}, 32'h0);
        @(negedge clk);
        check("stall_next", {28'd0, grant}, 32'h8);
        wait_drain(20, "stall_drain");

        // Backpressure never times out.
        tx_rdy = 1'b0;
        send(0, 8'hE0, 1'b1);
        wait_grant(4'b0001, 10, "bp_grant");
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (grant != 4'b0001 || req_ready != '0 || !tx_valid) bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        @(posedge clk);
        #2;
        tx_rdy = 1'b1;
        #1;
        check("bp_ready_now", {28'd0, req_ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        check("bp_release", {28'd0, grant}, 32'h0);
        wait_drain(20, "bp_drain");

        // Asynchronous reset in the middle of port 2's packet.
        send(2, 8'h51, 1'b0);
        send(2, 8'h52, 1'b0);
        send(2, 8'h53, 1'b0);
        send(2, 8'h54, 1'b1);
        wait_grant(4'b0100, 10, "arst_grant");
        #2;
        rst = 1'b1;
        #1;
        check("arst_outputs", {21'd0, grant, req_ready, tx_valid, busy, 1'b0}, 32'd0);
        pq.delete();
        exq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(0, 8'h60, 1'b1);
        send(2, 8'h61, 1'b1);
        bad = 1;
        for (int i = 0; i < 10 && bad != 0; i++) begin
            @(negedge clk);
            if (grant != '0) bad = 0;
        end
        check("arst_first_grant", {28'd0, grant}, 32'h1);
        wait_drain(30, "arst_drain");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
